// File: rtl/avst_keccak_pkg.sv
// Shared types and helpers for the Avalon-ST to Keccak padder byte ingress.
package avst_keccak_pkg;

   localparam int SYMBOLS_DEFAULT = 8;
   localparam int MAX_SYMBOLS     = 16;
   localparam int MAX_IDX_W       = 4;
   localparam int WORD_MAX_W      = 8 * MAX_SYMBOLS;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      PAD,
      DONE
   } state_t;

   // Word must be left-aligned to WORD_MAX_W; symbol 0 sits in the top byte.
   function automatic logic [7:0] byte_sel(input logic [WORD_MAX_W-1:0] word,
                                           input logic [MAX_IDX_W-1:0]  idx);
      logic [WORD_MAX_W-1:0] shifted;
      shifted = word << {idx, 3'b000};
      return shifted[WORD_MAX_W-1 -: 8];
   endfunction

endpackage

// File: rtl/avst_byte_ingress_if.sv
// Avalon-ST beat input plus padder byte output, bundled for the ingress block.
interface avst_byte_ingress_if
   import avst_keccak_pkg::*;
#(
   parameter int SYMBOLS = SYMBOLS_DEFAULT,
   parameter int EMPTY_W = $clog2(SYMBOLS)
) ();

   logic [8*SYMBOLS-1:0] st_data;
   logic                 st_valid;
   logic                 st_ready;
   logic                 st_sop;
   logic                 st_eop;
   logic [EMPTY_W-1:0]   st_empty;
   logic [7:0]           byte_out;
   logic                 byte_valid;
   logic                 byte_last;
   logic                 buffer_full;

   // Environment side: Avalon-ST source and padder together.
   modport master (
      output st_data, st_valid, st_sop, st_eop, st_empty, buffer_full,
      input  st_ready, byte_out, byte_valid, byte_last
   );

   modport slave (
      input  st_data, st_valid, st_sop, st_eop, st_empty, buffer_full,
      output st_ready, byte_out, byte_valid, byte_last
   );

endinterface

// File: rtl/avst_byte_ingress.sv
// Serialises one Avalon-ST packet into the Keccak padder byte interface,
// then issues the padder's last strobe only while its buffer has room.
module avst_byte_ingress
   import avst_keccak_pkg::*;
#(
   parameter int SYMBOLS = SYMBOLS_DEFAULT,
   parameter int EMPTY_W = $clog2(SYMBOLS)
) (
   input  logic               clk,
   input  logic               reset,
   avst_byte_ingress_if.slave bus,
   output logic               proto_err
);

   localparam int IDX_W  = $clog2(SYMBOLS);
   localparam int NB_W   = IDX_W + 1;
   localparam int WORD_W = 8 * SYMBOLS;

   state_t                  state, state_n;
   logic                    in_pkt, in_pkt_n;
   logic                    proto_err_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [WORD_W-1:0]       hold_word;
   logic [NB_W-1:0]         hold_nbytes;
   logic                    hold_eop;
   logic                    load;
   logic                    last_byte;
   logic [NB_W-1:0]         beat_nbytes;
   logic [WORD_MAX_W-1:0]   word_aligned;

   assign beat_nbytes  = bus.st_eop ? NB_W'(SYMBOLS) - NB_W'(bus.st_empty)
                                    : NB_W'(SYMBOLS);
   assign last_byte    = ({1'b0, idx} == hold_nbytes - NB_W'(1));
   assign word_aligned = WORD_MAX_W'(hold_word) << (WORD_MAX_W - WORD_W);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_pkt    <= 1'b0;
         idx       <= '0;
         proto_err <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values of its neighbours.
         state     <= state_n;
         in_pkt    <= in_pkt_n;
         idx       <= idx_n;
         proto_err <= proto_err_n;
      end
   end

   // NOTE: the holding register is pure data, always qualified by state, so it
   // is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (load) begin
         hold_word   <= bus.st_data;
         hold_nbytes <= beat_nbytes;
         hold_eop    <= bus.st_eop;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_n        = state;
      in_pkt_n       = in_pkt;
      idx_n          = idx;
      proto_err_n    = proto_err;
      load           = 1'b0;
      bus.st_ready   = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      bus.byte_out   = 8'h00;

      case (state)
         IDLE: begin
            bus.st_ready = 1'b1;
            if (bus.st_valid) begin
               if (!in_pkt && !bus.st_sop) begin
                  proto_err_n = 1'b1;
               end else begin
                  load     = 1'b1;
                  in_pkt_n = 1'b1;
                  idx_n    = '0;
                  state_n  = SEND;
               end
            end
         end

         SEND: begin
            bus.byte_valid = 1'b1;
            bus.byte_out   = byte_sel(word_aligned, MAX_IDX_W'(idx));
            if (!bus.buffer_full) begin
               if (!last_byte) begin
                  idx_n = idx + IDX_W'(1);
               end else if (hold_eop) begin
                  state_n = PAD;
               end else begin
                  // Open the beat input in the final byte cycle for a gapless reload.
                  bus.st_ready = 1'b1;
                  idx_n        = '0;
                  if (bus.st_valid) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
         end

         PAD: begin
            // The padder latches is_last unconditionally, so gate it with room.
            bus.byte_valid = !bus.buffer_full;
            bus.byte_last  = !bus.buffer_full;
            if (!bus.buffer_full) begin
               state_n = DONE;
            end
         end

         DONE: begin
            state_n = DONE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      if (reset) begin
         load           = 1'b0;
         bus.st_ready   = 1'b0;
         bus.byte_valid = 1'b0;
         bus.byte_last  = 1'b0;
         bus.byte_out   = 8'h00;
      end
   end

endmodule
